apb_rr_master: RTL and testbench

// - Shares one APB master port among NUM_REQ local requesters using round-robin arbitration.
// - Latches the granted request and drives the APB SETUP/ACCESS sequence.
// - Returns prdata/pslverr to the winning requester as a one-cycle done pulse.
// - Sits between CPU-side/DMA-side register agents and the APB peripheral fabric.

---
 rtl/apb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/apb_rr_master.sv | 136 +++++++++++++
 tb/tb_apb_rr_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int DEF_NUM_REQ        = 2;
  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_grant) + k;
      if (j >= N) j = j - N;
      if (!any_grant && req[j[IW-1:0]]) begin
        any_grant            = 1'b1;
        grant[j[IW-1:0]]     = 1'b1;
        grant_idx            = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin shared APB master; define APB_TIMEOUT_EN to bound ACCESS
// with a TIMEOUT_CYCLES watchdog that completes the transfer with an error.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int IW = idx_width(NUM_REQ);

  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("apb_rr_master: NUM_REQ must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("apb_rr_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e         state;
  logic [IW-1:0]      last_grant;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               timeout;
  logic               finish;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      to_cnt <= '0;
    end else if (state != ACCESS) begin
      to_cnt <= '0;
    end else if (!pready) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // Fires in the last allowed ACCESS cycle so done lands right after it
  assign timeout = (state == ACCESS) && !pready &&
                   (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign finish = (state == ACCESS) && (pready || timeout);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_oh   <= '0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            state      <= SETUP;
            last_grant <= arb_idx;
            grant_oh   <= arb_grant;
            paddr      <= req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            pwrite     <= req_write[arb_idx];
            pwdata     <= req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (finish) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_done  <= finish ? grant_oh : '0;
      rsp_err   <= finish && (timeout || pslverr);
      rsp_rdata <= (finish && !pwrite && !timeout) ? prdata : '0;
    end
  end

  // The granted requester must hold its request until its done pulse
  a_hold_req : assert property (
    @(posedge aclk) disable iff (areset)
    (state != IDLE) |-> ((grant_oh & ~req_valid) == '0)
  );

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master with a round-robin/timing model.
module tb_apb_rr_master;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel;
  logic [AW-1:0]   paddr;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  int checks = 0;
  int errors = 0;
  int rr_last = N - 1;

  always #5 aclk = ~aclk;

  apb_rr_master #(
    .NUM_REQ       (N),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_done (req_done),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .paddr    (paddr),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Rotation rule: scan starting one past the previous winner
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (rr_last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic reset_dut();
    areset    = 1'b1;
    req_valid = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    tick();
    tick();
    areset  = 1'b0;
    rr_last = N - 1;
  endtask

  // One transfer from an IDLE cycle through the done cycle
  task automatic xfer(input int waits, input logic [DW-1:0] rdat,
                      input logic serr, input bit jitter);
    int w;
    int seen;
    logic [AW-1:0] ea;
    logic ew;
    logic [DW-1:0] ed;
    w = pick(req_valid);
    if (w < 0) return;
    ea = req_addr[w*AW +: AW];
    ew = req_write[w];
    ed = req_wdata[w*DW +: DW];
    seen = 0;
    chk("idle_psel", {63'd0, psel}, 64'd0);
    tick();
    seen += int'(psel);
    chk("setup_phase", {62'd0, psel, penable}, 64'd2);
    chk("setup_fields", {19'd0, paddr, pwrite, pwdata}, {19'd0, ea, ew, ed});
    pready  = 1'($urandom);
    prdata  = $urandom;
    pslverr = 1'($urandom);
    for (int k = 0; k <= waits; k++) begin
      tick();
      seen += int'(psel);
      chk("access_phase", {62'd0, psel, penable}, 64'd3);
      chk("access_hold", {19'd0, paddr, pwrite, pwdata}, {19'd0, ea, ew, ed});
      chk("access_nodone", {62'd0, req_done}, 64'd0);
      pready  = (k == waits);
      prdata  = (k == waits) ? rdat : DW'($urandom);
      pslverr = (k == waits) ? serr : 1'($urandom);
      if (jitter)
        for (int i = 0; i < N; i++)
          if (i != w) req_valid[i] = 1'($urandom);
    end
    tick();
    seen += int'(psel);
    pready = 1'b0;
    chk("done_onehot", {62'd0, req_done}, 64'(1) << w);
    chk("done_rdata", {32'd0, rsp_rdata}, ew ? 64'd0 : {32'd0, rdat});
    chk("done_err", {63'd0, rsp_err}, {63'd0, serr});
    chk("done_idle", {62'd0, psel, penable}, 64'd0);
    chk("psel_cycles", 64'(seen), 64'(waits + 2));
    rr_last = w;
  endtask

  logic [N-1:0] v;
  int done_seen;

  initial begin
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    reset_dut();
    chk("rst_ctrl", {60'd0, psel, penable, pwrite, rsp_err}, 64'd0);
    chk("rst_done", {62'd0, req_done}, 64'd0);
    chk("rst_data", {rsp_rdata, pwdata}, 64'd0);
    chk("rst_paddr", {52'd0, paddr}, 64'd0);

    // single read with one wait state
    req_addr[0 +: AW] = 12'h010;
    req_write[0] = 1'b0;
    req_valid = 2'b01;
    xfer(1, 32'hDEADBEEF, 1'b0, 1'b0);
    req_valid = '0;
    tick();

    // write with slave error from requester 1
    req_addr[AW +: AW]  = 12'hFFC;
    req_write[1]        = 1'b1;
    req_wdata[DW +: DW] = 32'h5A5A5A5A;
    req_valid = 2'b10;
    xfer(0, DW'($urandom), 1'b1, 1'b0);
    req_valid = '0;
    tick();

    // contention: both held for four transfers
    req_addr  = {12'h2B0, 12'h1A0};
    req_write = 2'b00;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) xfer(0, DW'($urandom), 1'b0, 1'b0);
    req_valid = '0;
    tick();

    // back-to-back same requester
    req_write = 2'b01;
    req_valid = 2'b01;
    xfer(0, DW'($urandom), 1'b0, 1'b0);
    xfer(2, DW'($urandom), 1'b0, 1'b0);
    req_valid = '0;
    tick();

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW]  = AW'($urandom);
        req_write[i]          = 1'($urandom);
        req_wdata[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        tick();
      end
      req_valid = v;
      xfer($urandom_range(0, 3), DW'($urandom), 1'($urandom), 1'b1);
    end
    req_valid = '0;
    tick();

    // reset in the middle of ACCESS
    req_addr[0 +: AW] = 12'h123;
    req_write = 2'b00;
    req_valid = 2'b01;
    tick();
    tick();
    chk("rst_mid_access", {62'd0, psel, penable}, 64'd3);
    areset    = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_mid_async", {62'd0, psel, penable}, 64'd0);
    tick();
    chk("rst_mid_done", {62'd0, req_done}, 64'd0);
    tick();
    areset  = 1'b0;
    rr_last = N - 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_done", {61'd0, req_done, psel}, 64'd0);
    end
    req_valid = 2'b11;
    xfer(0, DW'($urandom), 1'b0, 1'b0);
    req_valid = '0;
    tick();

    // slave never ready
    req_write = 2'b00;
    req_valid = 2'b01;
    pready    = 1'b0;
    prdata    = 32'hCAFEF00D;
    pslverr   = 1'b0;
    tick();
`ifdef APB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      tick();
      chk("to_access", {62'd0, psel, penable}, 64'd3);
    end
    tick();
    chk("to_done", {62'd0, req_done}, 64'd1);
    chk("to_err", {63'd0, rsp_err}, 64'd1);
    chk("to_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("to_idle", {62'd0, psel, penable}, 64'd0);
    req_valid = '0;
    tick();
`else
    done_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (req_done != '0) done_seen++;
    end
    chk("no_to_done", 64'(done_seen), 64'd0);
    chk("no_to_access", {62'd0, psel, penable}, 64'd3);
    reset_dut();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
